// File: rtl/def_params.sv
`default_nettype none
// ============================================================================
//  Module   : def_params (package)
//  Purpose  : Shared widths, starvation default and requester index encoding
//             for the register-file writeback arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package def_params;

    localparam int REG_ADDR_SIZE = 4;
    localparam int REG_DATA_SIZE = 31;

    localparam int ADDR_W = REG_ADDR_SIZE + 1;
    localparam int DATA_W = REG_DATA_SIZE + 1;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int STARVE_CNT_W         = 4;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

endpackage : def_params
`default_nettype wire

// File: rtl/wb_hazard_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : wb_hazard_cmp
//  Purpose  : Flags a pending writeback to one decode-stage source register.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_hazard_cmp
    import def_params::*;
(
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              wr_enable,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              hazard
);

    logic w_chk_nonzero;
    logic w_hit_a;
    logic w_hit_b;
    logic w_hit_wr;

    // Register 0 is hardwired, so it can never carry a hazard.
    assign w_chk_nonzero = (chk_addr != '0);
    assign w_hit_a       = a_valid   && (a_addr  == chk_addr);
    assign w_hit_b       = b_valid   && (b_addr  == chk_addr);
    assign w_hit_wr      = wr_enable && (wr_addr == chk_addr);

    assign hazard = w_chk_nonzero && (w_hit_a || w_hit_b || w_hit_wr);

endmodule : wb_hazard_cmp
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Two-requester writeback arbiter (B priority, A anti-starvation)
//             driving a registered register-file write port, plus hazard check.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import def_params::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,

    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,

    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,

    input  logic [ADDR_W-1:0] chk_addr_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    output logic              hazard_1,
    output logic              hazard_2
);

    localparam logic [STARVE_CNT_W-1:0] c_starve_limit = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] c_starve_max   = '1;

    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic                    r_wr_enable;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;

    logic                    w_a_forced;
    logic                    w_a_ready;
    logic                    w_b_ready;
    logic                    w_xfer;
    req_idx_e                w_grant_idx;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [DATA_W-1:0]       w_sel_data;

    // B normally wins; A wins once it has been refused STARVE_LIMIT times in a row.
    assign w_a_forced = (r_starve_cnt >= c_starve_limit);
    assign w_a_ready  = !reset && a_valid && (!b_valid || w_a_forced);
    assign w_b_ready  = !reset && b_valid && !(a_valid && w_a_forced);
    assign w_xfer     = w_a_ready || w_b_ready;

    always_comb begin
        w_grant_idx = REQ_B;
        w_sel_addr  = b_addr;
        w_sel_data  = b_data;
        if (w_a_ready) begin
            w_grant_idx = REQ_A;
        end
        if (w_grant_idx == REQ_A) begin
            w_sel_addr = a_addr;
            w_sel_data = a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!a_valid || w_a_ready) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Writes to register 0 are accepted but never reach the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else if (w_xfer && (w_sel_addr != '0)) begin
            r_wr_enable <= 1'b1;
            r_wr_addr   <= w_sel_addr;
            r_wr_data   <= w_sel_data;
        end else begin
            r_wr_enable <= 1'b0;
        end
    end

    assign a_ready   = w_a_ready;
    assign b_ready   = w_b_ready;
    assign wr_enable = r_wr_enable;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

    logic [ADDR_W-1:0] w_chk_addr [2];
    logic              w_hazard   [2];

    assign w_chk_addr[0] = chk_addr_1;
    assign w_chk_addr[1] = chk_addr_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
            wb_hazard_cmp u_cmp (
                .chk_addr  (w_chk_addr[gi]),
                .a_valid   (a_valid),
                .a_addr    (a_addr),
                .b_valid   (b_valid),
                .b_addr    (b_addr),
                .wr_enable (r_wr_enable),
                .wr_addr   (r_wr_addr),
                .hazard    (w_hazard[gi])
            );
        end
    endgenerate

    assign hazard_1 = w_hazard[0];
    assign hazard_2 = w_hazard[1];

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter with a
//             write-port scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  chk_addr_1, chk_addr_2;
    logic        hazard_1, hazard_2;

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q [$];
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .wr_enable  (wr_enable),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .chk_addr_1 (chk_addr_1),
        .chk_addr_2 (chk_addr_2),
        .hazard_1   (hazard_1),
        .hazard_2   (hazard_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, check the grant, then check the write port one cycle later.
    task automatic step(input string tag, input logic rst,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic exp_ar, input logic exp_br);
        logic [36:0] e;
        reset = rst; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(exp_ar));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(exp_br));
        if (exp_ar && aa != 5'd0) exp_q.push_back({aa, ad});
        if (exp_br && ba != 5'd0) exp_q.push_back({ba, bd});
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            last_addr = 5'd0;
            last_data = 32'd0;
            chk({tag, ".wr_enable"}, 32'(wr_enable), 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_addr = e[36:32];
            last_data = e[31:0];
            chk({tag, ".wr_enable"}, 32'(wr_enable), 32'd1);
        end else begin
            chk({tag, ".wr_enable"}, 32'(wr_enable), 32'd0);
        end
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(last_addr));
        chk({tag, ".wr_data"}, wr_data, last_data);
    endtask

    initial begin
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        chk_addr_1 = '0; chk_addr_2 = '0;
        last_addr = '0; last_data = '0;
        @(posedge clk); #1;

        // Reset: no grants, write port cleared.
        step("rst0", 1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0);

        // Single A request.
        step("a_only", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        step("idle",   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // B to register 0: accepted and dropped.
        step("b_zero", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b1);

        // Contention: B wins four times, A forced on the fifth, then B again.
        step("st1", 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB1, 1'b0, 1'b1);
        step("st2", 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1);
        step("st3", 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB3, 1'b0, 1'b1);
        step("st4", 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB4, 1'b0, 1'b1);
        step("st5", 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB5, 1'b1, 1'b0);
        step("st6", 1'b0, 1'b1, 5'd1, 32'hA2, 1'b1, 5'd2, 32'hB6, 1'b0, 1'b1);
        step("idle2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Hazard on a pending A write, persisting through the write cycle.
        chk_addr_1 = 5'd7; chk_addr_2 = 5'd0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77; b_valid = 1'b0;
        #1;
        chk("haz_req.h1", 32'(hazard_1), 32'd1);
        chk("haz_req.h2", 32'(hazard_2), 32'd0);
        step("haz_wr", 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        a_valid = 1'b0;
        #1;
        chk("haz_wb.h1", 32'(hazard_1), 32'd1);
        chk("haz_wb.h2", 32'(hazard_2), 32'd0);
        chk_addr_1 = 5'd8;
        #1;
        chk("haz_miss.h1", 32'(hazard_1), 32'd0);
        step("idle3", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Same destination on both requesters: B first, then A.
        step("same_b", 1'b0, 1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0, 1'b1);
        step("same_a", 1'b0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("same.final_data", wr_data, 32'h1);

        // Reset while a write is on the port discards it.
        step("pre_rst", 1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst.wr_enable", 32'(wr_enable), 32'd1);
        chk_addr_1 = 5'd4;
        reset = 1'b1; a_valid = 1'b1; a_addr = 5'd4;
        #1;
        chk("rst_haz.h1", 32'(hazard_1), 32'd1);
        step("mid_rst", 1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive cycles requester A may be refused before it is forced to win; legal range 1..15.
REQ-002 Widths SHALL come from the shared defines: address `REG_ADDR_SIZE+1 bits (5), data `REG_DATA_SIZE+1 bits (32).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid  input  1  execute-stage writeback request.
REQ-006 a_addr  input  5  destination register of A.
REQ-007 a_data  input  32  writeback data of A.
REQ-008 a_ready  output  1  A accepted this cycle.
REQ-009 b_valid / b_addr / b_data  input  1/5/32  load-unit writeback request.
REQ-010 b_ready  output  1  B accepted this cycle.
REQ-011 wr_enable / wr_addr / wr_data  output  1/5/32  registered drive of the register-file write port.
REQ-012 chk_addr_1 / chk_addr_2  input  5/5  decode-stage source registers to check.
REQ-013 hazard_1 / hazard_2  output  1/1  pending write to the checked source register.

Function
REQ-014 A transfer SHALL occur when valid and ready are both high at a posedge; ready SHALL be combinational from valid, the starvation count and reset, and SHALL NOT depend on ready.
REQ-015 At most one of a_ready, b_ready SHALL be high per cycle; with a single valid requester, that requester SHALL be granted.
REQ-016 With both valid, B SHALL win, unless starve_cnt >= STARVE_LIMIT, in which case A SHALL win.
REQ-017 starve_cnt (4 bits) SHALL increment when a_valid=1 and a_ready=0, saturate at 15, and clear when A is granted or a_valid=0.
REQ-018 A granted transfer at cycle N SHALL produce wr_enable=1 with the captured addr/data in cycle N+1; latency is exactly one cycle.
REQ-019 With no transfer at cycle N, wr_enable SHALL be 0 in N+1; wr_addr/wr_data SHALL hold their previous values.
REQ-020 A granted transfer with addr 0 SHALL be accepted (ready high) and dropped: wr_enable=0 in N+1.
REQ-021 hazard_k SHALL be 1 when chk_addr_k != 0 and chk_addr_k equals any of: a_addr with a_valid, b_addr with b_valid, or wr_addr with wr_enable.
REQ-022 hazard outputs SHALL be combinational; chk_addr_k=0 SHALL never raise a hazard.
REQ-023 Same address on A and B in the same cycle SHALL be serialized by REQ-016; the later grant's data SHALL be written last.
REQ-024 Requester inputs SHALL be ignored when not granted; requesters hold addr/data stable while valid and not ready.

Reset
REQ-025 While reset=1: a_ready=0, b_ready=0; no transfer SHALL occur.
REQ-026 On the first posedge with reset=1: wr_enable=0, wr_addr=0, wr_data=0, starve_cnt=0.
REQ-027 Reset asserted while wr_enable=1 SHALL force wr_enable=0 in the next cycle; the pending write is discarded.
REQ-028 hazard outputs SHALL remain combinational during reset; they are masked only by wr_enable=0 after reset.

Structure
REQ-029 STARVE_LIMIT default, the address/data width defines and the requester index encoding (A=0, B=1) SHALL live in def_params.
REQ-030 The block SHALL be flat, except one natural sub-module, wb_hazard_cmp, instantiated once per check port.

Verification
REQ-031 Only A valid, addr 5, data 0xDEADBEEF -> a_ready=1 at N; wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF at N+1.
REQ-032 A and B valid continuously, STARVE_LIMIT=4 -> B granted for 4 cycles, A on the 5th, starve_cnt=0 afterwards.
REQ-033 B valid, addr 0 -> b_ready=1, wr_enable stays 0.
REQ-034 A valid addr 7, chk_addr_1=7, chk_addr_2=0 -> hazard_1=1, hazard_2=0, and hazard_1 stays 1 through the wr_enable cycle.
REQ-035 Reset at the cycle wr_enable=1 for addr 3 -> wr_enable=0, wr_addr=0 next cycle; both readies 0 while reset is high.
REQ-036 A and B both valid to addr 9 (A=0x1, B=0x2) -> B written first, then A; final wr_data=0x1.
